// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: loadable down-counter with a start/busy/done handshake.
// A controller loads a budget with start_i, the block counts it down on en_i,
// and done_o pulses for one cycle at terminal count. clr_i aborts at any time.
//
// Build option CNT_AUTO_RELOAD_EN: when defined, terminal count reloads the
// captured load value and the block stays in RUN. This makes it a periodic
// tick generator that only clr_i or reset returns to IDLE. When the macro is
// undefined the block is one-shot and has no reload register.
module down_counter_ctrl #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_ff,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t state_reg;

`ifdef CNT_AUTO_RELOAD_EN
    logic [CNT_WIDTH-1:0] reload_reg;
`endif

    // While RUN, the count is at least 1. Treating a count of 0 as terminal
    // as well means a corrupted count cannot wrap around to the maximum.
    logic at_terminal;
    assign at_terminal = (cnt_ff <= CNT_ONE);

    // Control FSM. Count, busy and done are all registered alongside the
    // state. Priority on each edge is clr, then start (IDLE), then en (RUN).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            cnt_ff     <= CNT_ZERO;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
`ifdef CNT_AUTO_RELOAD_EN
            reload_reg <= CNT_ZERO;
`endif
        end else begin
            // done is a pulse: it is cleared every cycle unless set below.
            done_o <= 1'b0;

            if (clr_i) begin
                // Abort wins over everything. A terminal count on the
                // same edge is discarded, so done stays low.
                state_reg <= IDLE;
                cnt_ff    <= CNT_ZERO;
                busy_o    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_i) begin
                            if (load_val_i != CNT_ZERO) begin
                                cnt_ff     <= load_val_i;
`ifdef CNT_AUTO_RELOAD_EN
                                reload_reg <= load_val_i;
`endif
                                state_reg  <= RUN;
                                busy_o     <= 1'b1;
                            end else begin
                                // A zero-length job completes at once and
                                // never enters RUN.
                                cnt_ff <= CNT_ZERO;
                                done_o <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        // start_i is ignored here. Nothing is queued.
                        if (en_i) begin
                            if (at_terminal) begin
                                done_o <= 1'b1;
`ifdef CNT_AUTO_RELOAD_EN
                                cnt_ff <= reload_reg;
`else
                                cnt_ff    <= CNT_ZERO;
                                state_reg <= IDLE;
                                busy_o    <= 1'b0;
`endif
                            end else begin
                                cnt_ff <= cnt_ff - CNT_ONE;
                            end
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                        cnt_ff    <= CNT_ZERO;
                        busy_o    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Randomised and directed bench for down_counter_ctrl.
// The reference model tracks the job in plain integers: whether a job is
// active, how many enabled cycles remain, and the original budget.
module tb_down_counter_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] load_val;
    logic         en;
    logic         clr;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_active;
    int m_remaining;
    int m_budget;
    bit m_done;

    down_counter_ctrl #(.CNT_WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .load_val_i (load_val),
        .en_i       (en),
        .clr_i      (clr),
        .cnt_ff     (cnt),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_remaining = 0;
        m_budget    = 0;
        m_done      = 1'b0;
    endtask

    // Apply the job rules to the model once per clock edge.
    task automatic model_edge(input bit s, input int lv, input bit e, input bit c);
        m_done = 1'b0;
        if (c) begin
            m_active    = 1'b0;
            m_remaining = 0;
        end else if (!m_active) begin
            if (s) begin
                if (lv == 0) begin
                    m_remaining = 0;
                    m_done      = 1'b1;
                end else begin
                    m_active    = 1'b1;
                    m_remaining = lv;
                    m_budget    = lv;
                end
            end
        end else if (e) begin
            m_remaining = m_remaining - 1;
            if (m_remaining == 0) begin
                m_done = 1'b1;
`ifdef CNT_AUTO_RELOAD_EN
                m_remaining = m_budget;
`else
                m_active = 1'b0;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, advance one edge, and compare all outputs.
    task automatic step(input bit s, input int lv, input bit e, input bit c);
        start    = s;
        load_val = W'(lv);
        en       = e;
        clr      = c;
        @(posedge clk);
        model_edge(s, lv, e, c);
        #1;
        chk("cnt", 32'(cnt), 32'(m_remaining));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        $display("step s=%0b lv=%0d en=%0b clr=%0b -> cnt=%0d busy=%0b done=%0b",
                 s, lv, e, c, cnt, busy, done);
    endtask

    initial begin
        int dones;
        bit s, e, c;
        int lv;

        rst_n    = 1'b0;
        start    = 1'b0;
        load_val = '0;
        en       = 1'b0;
        clr      = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Load 5, en high: 5,4,3,2,1,0 then a single done pulse
        step(1, 5, 1, 0);
        chk("ld5_first", 32'(cnt), 5);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
`ifndef CNT_AUTO_RELOAD_EN
            chk("ld5_seq", 32'(cnt), 32'(4 - i));
`endif
            dones += int'(done);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            dones += int'(done);
        end
`ifndef CNT_AUTO_RELOAD_EN
        chk("ld5_done_count", 32'(dones), 1);
        chk("ld5_hold_zero", 32'(cnt), 0);
`endif
        step(0, 0, 0, 1);

        // Load 4 with en toggling: done after the 4th enabled edge
        step(1, 4, 0, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, (i % 2) == 0, 0);
            if (done && dones == 0) chk("tog_done_idx", 32'(i), 6);
            dones += int'(done);
        end
        chk("tog_done_count", 32'(dones), 1);
        step(0, 0, 0, 1);

        // Clear while counting at 2: no done afterwards
        step(1, 4, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("clr_pre_cnt", 32'(cnt), 2);
        step(0, 0, 1, 1);
        chk("clr_cnt", 32'(cnt), 0);
        chk("clr_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        // clr together with start in IDLE: the start is dropped
        step(1, 5, 0, 1);
        chk("clr_start_busy", 32'(busy), 0);

        // Zero-length job
        step(1, 0, 0, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        step(0, 0, 0, 0);

        // Back-to-back: start held across the done cycle, load 3
        step(1, 3, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 3, 1, 0);
`ifndef CNT_AUTO_RELOAD_EN
        chk("b2b_done", 32'(done), 1);
        step(1, 3, 1, 0);
        chk("b2b_restart_cnt", 32'(cnt), 3);
        chk("b2b_restart_busy", 32'(busy), 1);
`endif
        step(0, 0, 0, 1);

        // Asynchronous reset mid-count: load 15, wait for 7
        step(1, 15, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        chk("arst_pre_cnt", 32'(cnt), 7);
        start = 1'b0;
        en    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        #3;
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 1, 0);
        chk("arst_idle", 32'(busy), 0);

`ifdef CNT_AUTO_RELOAD_EN
        // Periodic mode: load 3, ten enabled edges, three done pulses
        step(1, 3, 0, 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            dones += int'(done);
            chk("auto_busy", 32'(busy), 1);
        end
        chk("auto_done_count", 32'(dones), 3);
        step(0, 0, 0, 1);
        chk("auto_clr_busy", 32'(busy), 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
            step(s, lv, e, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter_ctrl.md
# down_counter_ctrl

Loadable down-counter with start/busy/done handshake, used in the fitness-evaluation datapath as the terminating end of the up-counter protocol: the controller loads a cycle or item budget, the block counts it down on `en_i`, and emits a single-cycle `done_o` at terminal count. It shares the up-counter's `en_i`/`clr_i` semantics, so sequencers drive either block the same way. A compile-time option turns it into a periodic tick generator.

## Interface
- `CNT_WIDTH`, default 4: width of the count and load value.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  load-and-go request; sampled only in IDLE.
- `load_val_i`  in  CNT_WIDTH  initial count, captured when `start_i` is accepted.
- `en_i`  in  1  decrement enable; only acts in RUN.
- `clr_i`  in  1  synchronous abort; highest priority.
- `cnt_ff`  out  CNT_WIDTH  current count (registered).
- `busy_o`  out  1  high while in RUN (registered state decode).
- `done_o`  out  1  one-cycle registered terminal-count pulse.

## Operation
- Reset: state IDLE, `cnt_ff`=0, `busy_o`=0, `done_o`=0; reload register = 0.
- States: IDLE, RUN. `done_o` is a separate flag register, default 0 every cycle unless set below.
- Per-edge priority: `clr_i` > `start_i` (IDLE only) > `en_i` (RUN only) > hold.
- `clr_i`=1, any state: next state IDLE, `cnt_ff`=0, `done_o`=0. Any pending terminal count that same edge is discarded.
- IDLE, `start_i`=1, `load_val_i`≠0: `cnt_ff`←`load_val_i`, reload register ← `load_val_i`, state ← RUN.
- IDLE, `start_i`=1, `load_val_i`=0: stay IDLE, `cnt_ff`=0, `done_o`←1 (zero-length job).
- RUN, `en_i`=1, `cnt_ff`>1: `cnt_ff`←`cnt_ff`−1.
- RUN, `en_i`=1, `cnt_ff`=1: terminal count: `cnt_ff`←0, `done_o`←1, state ← IDLE (see Configuration).
- RUN, `en_i`=0: hold `cnt_ff` and state.
- `start_i` in RUN is ignored; no queuing.
- Arithmetic is unsigned CNT_WIDTH. `cnt_ff` never wraps below 0. Max load 2^CNT_WIDTH−1.

## Timing
- `start_i` accepted at edge k: `busy_o`=1 and `cnt_ff`=N visible after edge k.
- With `en_i` held high from edge k+1, `cnt_ff` reaches 0 at edge k+N. `done_o`=1 for exactly the cycle after edge k+N, and `busy_o`=0 from that same edge.
- Back-to-back: `start_i` may be asserted in the cycle `done_o` is high (state is IDLE). It is accepted at the next edge with no bubble.
- Reset asserted mid-RUN forces all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- `CNT_AUTO_RELOAD_EN` defined: at terminal count in RUN, `cnt_ff`←reload register, state stays RUN, `busy_o` stays 1, and `done_o` pulses for one cycle every N enabled cycles. Only `clr_i` or reset returns the block to IDLE. A zero load still behaves as the one-shot zero-length job.
- `CNT_AUTO_RELOAD_EN` not defined: the block is one-shot as described in Operation, and the reload register may be optimised away.

## Test plan
- Reset, then `start_i` with `load_val_i`=5 and `en_i` held high: `cnt_ff` counts 5,4,3,2,1,0. `done_o` is high for exactly one cycle, `busy_o` falls with it, and `cnt_ff` stays 0.
- `load_val_i`=4, `en_i` toggled 1,0,1,0…: `cnt_ff` holds on every `en_i`=0 cycle. `done_o` arrives after the 4th enabled edge.
- `clr_i` pulsed while `cnt_ff`=2 in RUN: next cycle `cnt_ff`=0, `busy_o`=0, and `done_o` never asserts. Also `clr_i` and `start_i` together in IDLE: the start is ignored.
- `start_i` with `load_val_i`=0: `done_o` pulses next cycle and `busy_o` stays 0. Separately, `start_i` held high across a `done_o` cycle with `load_val_i`=3: the second job starts without a gap.
- `rst_n_i` dropped asynchronously mid-count (`cnt_ff`=7, CNT_WIDTH=4, load 15): all outputs go to 0 before the next edge. After release, the block is in IDLE.
- `CNT_AUTO_RELOAD_EN` build, load 3, `en_i` high for 10 cycles: `done_o` pulses on enabled edges 3, 6 and 9, `cnt_ff` sequence is 3,2,1,3,2,1,…, and `busy_o` stays 1 until `clr_i`.
